// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder -- bit-serial ripple adder built around one full-adder cell.
//
// Operands are accepted on a valid/ready handshake, added LSB-first at one bit
// per clock through a single `fa` instance with a registered carry, and the
// result is presented on a valid/ready output handshake.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the Sub port
// (Sub=1 computes A-B by loading ~B and seeding the carry with 1).
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   In_valid   in   A/B/Cin (and Sub) are valid
//   In_ready   out  block can accept operands (state == IDLE)
//   A, B       in   WIDTH-bit operands
//   Cin        in   carry-in seed
//   Sub        in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   Out_valid  out  Sum/Cout/Overflow hold a completed result
//   Out_ready  in   consumer accepts the result
//   Sum        out  WIDTH-bit result, registered
//   Cout       out  carry out of bit WIDTH-1, registered
//   Overflow   out  signed overflow, registered
// -----------------------------------------------------------------------------

// One-bit full adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             fa_s, fa_co;
    logic             last_bit;
    logic [WIDTH-1:0] s_sr_shifted;

    fa u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit     = (cnt_q == LAST_BIT);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign s_sr_shifted = {fa_s, s_sr_q[WIDTH-1:1]};

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (In_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = HOLD;
            HOLD:    if (Out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output decode: In_ready comes from the state register only, so there
    // is no combinational path from Out_ready.
    always_comb begin
        In_ready = (state_q == IDLE);
    end

    // Datapath next-values.
    always_comb begin
        // NOTE: every target gets a hold default first so no branch can leave
        // one unassigned and infer a latch.
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        s_sr_d      = s_sr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (In_valid) begin
                    a_sr_d = A;
                    s_sr_d = '0;
                    cnt_d  = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    // A - B = A + ~B + 1; Cin is ignored when subtracting.
                    b_sr_d  = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
`else
                    b_sr_d  = B;
                    carry_d = Cin;
`endif
                end
            end
            RUN: begin
                s_sr_d  = s_sr_shifted;
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d       = s_sr_shifted;
                    cout_d      = fa_co;
                    // carry_q is the carry into the MSB on this edge.
                    ovf_d       = carry_q ^ fa_co;
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (Out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and result registers; reset discards any in-flight operation.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            s_sr_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            s_sr_q      <= s_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Overflow  = ovf_q;
    assign Out_valid = out_valid_q;

endmodule
